// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues in-order word reads to instruction memory and
// queues returned {pc, instruction} pairs for decode; redirects flush and re-steer.
module instr_fetch #(
  parameter int                    INSTRUCTION_WIDTH = 32,
  parameter int                    ADDR_WIDTH        = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC          = '0,
  parameter int                    DEPTH             = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         imem_req_valid,
  input  logic                         imem_req_ready,
  output logic [ADDR_WIDTH-1:0]        imem_req_addr,
  input  logic                         imem_rsp_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_rsp_data,
  input  logic                         redirect_valid,
  input  logic [ADDR_WIDTH-1:0]        redirect_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INSTRUCTION_WIDTH-1:0] out_instruction,
  output logic [ADDR_WIDTH-1:0]        out_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [ADDR_WIDTH-1:0]        pc_q, pc_d;
  logic [CW-1:0]                outst_q, outst_d;
  logic [CW-1:0]                discard_q, discard_d;
  logic [CW-1:0]                fcnt_q, fcnt_d;
  logic [PW-1:0]                frd_q, frd_d, fwr_q, fwr_d;
  logic [PW-1:0]                trd_q, trd_d, twr_q, twr_d;

  logic [ADDR_WIDTH-1:0]        fifo_pc_q  [DEPTH];
  logic [INSTRUCTION_WIDTH-1:0] fifo_ins_q [DEPTH];
  logic [ADDR_WIDTH-1:0]        tag_q      [DEPTH];

  logic [CW:0] inflight;
  logic        fifo_empty, req_fire, rsp_seen, fifo_push, out_fire;
  logic [1:0]  unused_redirect_lsb;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign unused_redirect_lsb = redirect_pc[1:0];

  // Discarded requests still occupy a slot in inflight, so every live response
  // is guaranteed a FIFO entry.
  always_comb begin
    inflight        = {1'b0, outst_q} + {1'b0, fcnt_q};
    fifo_empty      = (fcnt_q == '0);
    imem_req_valid  = !rst && !redirect_valid && (inflight < (CW+1)'(DEPTH));
    imem_req_addr   = pc_q;
    req_fire        = imem_req_valid && imem_req_ready;
    rsp_seen        = !rst && imem_rsp_valid && (outst_q != '0);
    fifo_push       = rsp_seen && !redirect_valid && (discard_q == '0);
    out_valid       = !rst && !fifo_empty && !redirect_valid;
    out_fire        = out_valid && out_ready;
    out_pc          = (!rst && !fifo_empty) ? fifo_pc_q[frd_q]  : '0;
    out_instruction = (!rst && !fifo_empty) ? fifo_ins_q[frd_q] : '0;
  end

  always_comb begin
    pc_d      = pc_q;
    outst_d   = outst_q + CW'(req_fire) - CW'(rsp_seen);
    discard_d = discard_q;
    frd_d     = frd_q;
    fwr_d     = fwr_q;
    trd_d     = trd_q;
    twr_d     = twr_q;
    fcnt_d    = fcnt_q + CW'(fifo_push) - CW'(out_fire);
    if (req_fire) begin
      pc_d  = pc_q + ADDR_WIDTH'(4);
      twr_d = ptr_inc(twr_q);
    end
    if (rsp_seen && discard_q != '0) begin
      discard_d = discard_q - CW'(1);
    end
    if (fifo_push) begin
      trd_d = ptr_inc(trd_q);
      fwr_d = ptr_inc(fwr_q);
    end
    if (out_fire) begin
      frd_d = ptr_inc(frd_q);
    end
    // Everything still owed by memory after this cycle belongs to the old path.
    if (redirect_valid) begin
      pc_d      = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      discard_d = outst_d;
      frd_d     = '0;
      fwr_d     = '0;
      trd_d     = '0;
      twr_d     = '0;
      fcnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      outst_q   <= '0;
      discard_q <= '0;
      fcnt_q    <= '0;
      frd_q     <= '0;
      fwr_q     <= '0;
      trd_q     <= '0;
      twr_q     <= '0;
    end else begin
      pc_q      <= pc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      fcnt_q    <= fcnt_d;
      frd_q     <= frd_d;
      fwr_q     <= fwr_d;
      trd_q     <= trd_d;
      twr_q     <= twr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      tag_q[twr_q] <= pc_q;
    end
    if (fifo_push) begin
      fifo_pc_q[fwr_q]  <= tag_q[trd_q];
      fifo_ins_q[fwr_q] <= imem_rsp_data;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    fifo_push |-> (fcnt_q != CW'(DEPTH)) || out_fire);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a latency-configurable memory model feeds the DUT,
// stimulus queues hand-computed {pc, instruction} pairs and a monitor checks transfers.
module tb_instr_fetch;

  localparam logic [31:0] K = 32'hC0DE_0000;

  typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_instruction, out_pc;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    c0 = 0;
  int    mem_lat = 1;
  int    acc_cnt = 0;
  exp_t  exp_q[$];
  mreq_t mq[$];
  int    pop_cyc_q[$];

  instr_fetch #(
    .INSTRUCTION_WIDTH(32),
    .ADDR_WIDTH(32),
    .RESET_PC(32'h0000_0100),
    .DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instruction(out_instruction),
    .out_pc(out_pc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: accepts are sampled mid-cycle, data = addr ^ K returned mem_lat cycles later.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      mq.delete();
    end else if (imem_req_valid && imem_req_ready) begin
      mq.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
      acc_cnt++;
    end
  end

  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(posedge clk); #1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        mreq_t m;
        m = mq.pop_front();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = m.addr ^ K;
      end
    end
  end

  // Scoreboard monitor.
  initial forever begin
    @(negedge clk);
    if (!rst && out_valid && out_ready && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (out_pc !== e.pc || out_instruction !== e.ins) begin
        errors++;
        $display("FAIL out_entry pc=%h ins=%h required pc=%h ins=%h",
                 out_pc, out_instruction, e.pc, e.ins);
      end
      pop_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back('{pc: pc, ins: pc ^ K});
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    redirect_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_req_addr", imem_req_addr, 32'h100);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_ins", out_instruction, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    c0 = cyc;
    acc_cnt = 0;
    exp_q.delete();
    pop_cyc_q.delete();
    @(negedge clk);
    chk("first_req_valid", 32'(imem_req_valid), 32'h1);
    chk("first_req_addr", imem_req_addr, 32'h100);
    chk("first_out_valid", 32'(out_valid), 32'h0);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain left=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // first_rel < 0 skips the absolute start cycle and only checks for gaps.
  task automatic chk_stream(input string name, input int first_rel);
    int bad = 0;
    int first = -1;
    if (pop_cyc_q.size() == 0) bad = 1;
    else begin
      first = pop_cyc_q[0] - c0;
      if (first_rel >= 0 && first != first_rel) bad = 1;
      for (int i = 1; i < pop_cyc_q.size(); i++)
        if (pop_cyc_q[i] - pop_cyc_q[i-1] != 1) bad = 1;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s first_cycle=%0d pops=%0d required first=%0d back-to-back",
               name, first, pop_cyc_q.size(), first_rel);
    end
  endtask

  initial begin
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;

    // Sequential fetch.
    mem_lat = 1; out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) push_exp(32'h100 + 32'(4 * i));
    drain("seq");
    chk_stream("seq_timing", 2);

    // Back-pressure from decode.
    mem_lat = 1; out_ready = 1'b0;
    do_reset();
    tick(10);
    @(negedge clk);
    chk("bp_req_count", 32'(acc_cnt), 32'd4);
    chk("bp_out_valid", 32'(out_valid), 32'h1);
    chk("bp_out_pc", out_pc, 32'h100);
    chk("bp_req_valid", 32'(imem_req_valid), 32'h0);
    for (int i = 0; i < 6; i++) push_exp(32'h100 + 32'(4 * i));
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain("bp");
    chk_stream("bp_stream", -1);

    // Memory stall.
    mem_lat = 1; out_ready = 1'b1; imem_req_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_addr", imem_req_addr, 32'h100);
      chk("stall_valids", {30'b0, out_valid, imem_req_valid}, 32'h1);
    end
    @(posedge clk); #1;
    imem_req_ready = 1'b1;
    push_exp(32'h100); push_exp(32'h104); push_exp(32'h108);
    drain("stall");

    // Redirect with three requests outstanding.
    mem_lat = 4; out_ready = 1'b1;
    do_reset();
    tick(3);
    redirect_valid = 1'b1; redirect_pc = 32'h2003;
    push_exp(32'h2000); push_exp(32'h2004); push_exp(32'h2008);
    @(negedge clk);
    chk("redir_outstanding", 32'(acc_cnt), 32'd3);
    chk("redir_req_valid", 32'(imem_req_valid), 32'h0);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir_new_req_valid", 32'(imem_req_valid), 32'h1);
    chk("redir_new_req_addr", imem_req_addr, 32'h2000);
    drain("redir");
    chk_stream("redir_timing", 9);

    // Redirect coincident with a response while the FIFO holds entries.
    mem_lat = 1; out_ready = 1'b0;
    do_reset();
    tick(3);
    redirect_valid = 1'b1; redirect_pc = 32'h3000; out_ready = 1'b1;
    push_exp(32'h3000); push_exp(32'h3004); push_exp(32'h3008);
    @(negedge clk);
    chk("coinc_out_valid", 32'(out_valid), 32'h0);
    chk("coinc_req_valid", 32'(imem_req_valid), 32'h0);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    drain("coinc");
    chk_stream("coinc_timing", 6);

    // PC wrap-around.
    mem_lat = 1; out_ready = 1'b1;
    do_reset();
    tick(1);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    push_exp(32'hFFFF_FFFC); push_exp(32'h0000_0000); push_exp(32'h0000_0004);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    drain("wrap");
    chk_stream("wrap_timing", 4);

    // Back-to-back redirects: the second one wins.
    mem_lat = 4; out_ready = 1'b1;
    do_reset();
    tick(3);
    redirect_valid = 1'b1; redirect_pc = 32'h4000;
    tick(1);
    redirect_pc = 32'h5000;
    push_exp(32'h5000); push_exp(32'h5004);
    tick(1);
    redirect_valid = 1'b0;
    drain("b2b");
    chk_stream("b2b_timing", 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
